// File: rtl/mips_int_pkg.sv
// Shared definitions for the MIPS interrupt controller.
// Latency: none (constants and types only).
// Backpressure: not applicable.
// Contents: register address map, controller state enum, status bit positions.
package mips_int_pkg;

  // Configuration register map (cfg_addr)
  localparam logic [1:0] CFG_ENABLE = 2'd0;
  localparam logic [1:0] CFG_MODE   = 2'd1;
  localparam logic [1:0] CFG_PEND   = 2'd2;  // write-1-to-clear
  localparam logic [1:0] CFG_STATUS = 2'd3;  // read-only

  // Status word layout: in_service flag at the top, active id at the bottom
  localparam int STAT_INSVC_BIT = 31;
  localparam int STAT_ID_LSB    = 0;

  // Request/acknowledge/done handshake towards the core
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_e;

endpackage

// File: rtl/mips_irq_prio.sv
// Fixed-priority encoder: lowest set index of req wins.
// Latency: purely combinational.
// Backpressure: not applicable.
// Ports: req (one bit per channel) -> any_valid (some bit set), id (winning index).
module mips_irq_prio #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any_valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    any_valid = 1'b0;
    id        = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_valid = 1'b1;
        id        = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/mips_int_ctrl.sv
// Multi-channel interrupt controller feeding the MIPS core's single interrupt input.
// Latency: int_req rises 2 cycles after a source edge; cfg_rdata is combinational.
// Backpressure: int_req held until int_ack; no new request until int_done returns to IDLE.
// Ports: clk/rst (sync, active-high); irq_in sources; cfg_we/cfg_addr/cfg_wdata/cfg_rdata
//        register port; int_req/int_id/int_ack/int_done core handshake.
module mips_int_ctrl
  import mips_int_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0] ENABLE_RST = '1,
  parameter logic [NUM_IRQ-1:0] MODE_RST   = '1,   // 1 = edge, 0 = level
  parameter int                 ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  input  logic               int_done
);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pend_q,  pend_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  int_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q,    id_d;

  // Upper write-data bits beyond NUM_IRQ have no meaning here.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  // ------------------------------------------------------------------
  // Pending update
  // ------------------------------------------------------------------
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               ack_take;

  assign ack_take = (state_q == REQ) && int_ack;

  always_comb begin
    edge_set = irq_in & ~irq_prev_q;
    w1c_clr  = '0;
    ack_clr  = '0;
    if (cfg_we && (cfg_addr == CFG_PEND)) begin
      w1c_clr = cfg_wdata[NUM_IRQ-1:0];
    end
    if (ack_take) begin
      ack_clr = NUM_IRQ'(1) << id_q;
    end
    // Edge channels: set beats clear. Level channels simply mirror the line,
    // which also makes W1C and ack clears irrelevant for them.
    pend_d = (mode_q  & ((pend_q & ~(w1c_clr | ack_clr)) | edge_set))
           | (~mode_q & irq_in);
  end

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  logic [NUM_IRQ-1:0] eligible;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;

  assign eligible = pend_q & enable_q;

  mips_irq_prio #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req       (eligible),
    .any_valid (win_vld),
    .id        (win_id)
  );

  // ------------------------------------------------------------------
  // Handshake FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          state_d = REQ;
        end
      end
      // Once raised, the request stands even if the channel gets masked or
      // cleared; the core is already committed to taking it.
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q   <= ENABLE_RST;
      mode_q     <= MODE_RST;
      pend_q     <= '0;
      irq_prev_q <= '0;
      state_q    <= IDLE;
      id_q       <= '0;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= irq_in;
      state_q    <= state_d;
      id_q       <= id_d;
      if (cfg_we && (cfg_addr == CFG_ENABLE)) begin
        enable_q <= cfg_wdata[NUM_IRQ-1:0];
      end
      if (cfg_we && (cfg_addr == CFG_MODE)) begin
        mode_q <= cfg_wdata[NUM_IRQ-1:0];
      end
    end
  end

  assign int_req = (state_q == REQ);
  assign int_id  = id_q;

  // ------------------------------------------------------------------
  // Register read port
  // ------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word                             = '0;
    status_word[STAT_ID_LSB +: ID_W]        = id_q;
    status_word[STAT_INSVC_BIT]             = (state_q == SERVICE);
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      CFG_ENABLE: cfg_rdata = 32'(enable_q);
      CFG_MODE:   cfg_rdata = 32'(mode_q);
      CFG_PEND:   cfg_rdata = 32'(pend_q);
      CFG_STATUS: cfg_rdata = status_word;
      default:    cfg_rdata = '0;
    endcase
  end

endmodule
